// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and types for the pipeline hazard controller
//   REG_W      : default register index width
//   FWD_*      : EX operand mux select encodings
//   shadow_t   : in-flight destination record {v, dst, we, ld}
package pipeline_pkg;
   localparam int REG_W = 3;
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;
   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] dst;
      logic             we;
      logic             ld;
   } shadow_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: datapath <-> hazard controller bundle
//   master : datapath side, drives decoded ID fields and the EX branch outcome
//   slave  : controller side, drives enables, flush/bubble, forwarding selects, stall counter
interface pipeline_hazard_ctrl_if
   import pipeline_pkg::*;
#(
   parameter int RW    = REG_W,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [RW-1:0]    id_src1;
   logic             id_src1_used;
   logic [RW-1:0]    id_src2;
   logic             id_src2_used;
   logic [RW-1:0]    id_dst;
   logic             id_dst_we;
   logic             id_is_load;
   logic             ex_branch_taken;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       fwd1_sel;
   logic [1:0]       fwd2_sel;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
             id_dst, id_dst_we, id_is_load, ex_branch_taken,
      input  pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd1_sel, fwd2_sel, stall_cnt
   );
   modport slave (
      input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
             id_dst, id_dst_we, id_is_load, ex_branch_taken,
      output pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd1_sel, fwd2_sel, stall_cnt
   );
endinterface

// File: rtl/hazard_src_cmp.sv
// hazard_src_cmp: compares one ID source register against the EX and MEM shadow entries
//   src, used        : source index and whether it is actually read
//   ex_*             : EX shadow entry {v, dst, we, ld}
//   mem_*            : MEM shadow entry {v, dst, we}
//   hit_ex/_load/mem : source produced by EX, by a load in EX, by MEM
module hazard_src_cmp
   import pipeline_pkg::*;
#(
   parameter int RW = REG_W
) (
   input  logic [RW-1:0] src,
   input  logic          used,
   input  logic          ex_v,
   input  logic [RW-1:0] ex_dst,
   input  logic          ex_we,
   input  logic          ex_ld,
   input  logic          mem_v,
   input  logic [RW-1:0] mem_dst,
   input  logic          mem_we,
   output logic          hit_ex,
   output logic          hit_ex_load,
   output logic          hit_mem
);
   assign hit_ex      = used & ex_v & ex_we & (ex_dst == src);
   assign hit_ex_load = hit_ex & ex_ld;
   assign hit_mem     = used & mem_v & mem_we & (mem_dst == src);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW hazard detection, operand forwarding, load-use stall and branch flush
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of pipeline_hazard_ctrl_if
//   FWD_EN     : 1 = forward with load-use stall, 0 = stall until the producer reaches WB
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int RW     = REG_W,
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input logic clk,
   input logic rst_n,
   pipeline_hazard_ctrl_if.slave bus
);
   typedef struct packed {
      logic          v;
      logic [RW-1:0] dst;
      logic          we;
      logic          ld;
   } ex_t;
   // Once in MEM a load's data is forwardable, so the load flag is dropped; WB is not
   // tracked at all because the register file writes before it reads.
   typedef struct packed {
      logic          v;
      logic [RW-1:0] dst;
      logic          we;
   } mem_t;

   ex_t              ex_q;
   mem_t             mem_q;
   logic             h1_ex, h1_exl, h1_mem, h2_ex, h2_exl, h2_mem;
   logic             stall, flush, bubble;
   logic [1:0]       f1_d, f2_d, f1_q, f2_q;
   logic [CNT_W-1:0] cnt_q;

   hazard_src_cmp #(.RW(RW)) u_cmp1 (
      .src(bus.id_src1), .used(bus.id_src1_used),
      .ex_v(ex_q.v), .ex_dst(ex_q.dst), .ex_we(ex_q.we), .ex_ld(ex_q.ld),
      .mem_v(mem_q.v), .mem_dst(mem_q.dst), .mem_we(mem_q.we),
      .hit_ex(h1_ex), .hit_ex_load(h1_exl), .hit_mem(h1_mem)
   );
   hazard_src_cmp #(.RW(RW)) u_cmp2 (
      .src(bus.id_src2), .used(bus.id_src2_used),
      .ex_v(ex_q.v), .ex_dst(ex_q.dst), .ex_we(ex_q.we), .ex_ld(ex_q.ld),
      .mem_v(mem_q.v), .mem_dst(mem_q.dst), .mem_we(mem_q.we),
      .hit_ex(h2_ex), .hit_ex_load(h2_exl), .hit_mem(h2_mem)
   );

   // The younger producer in EX wins over MEM; a bubble sends a NOP into EX, which needs no operands.
   always_comb begin
      flush  = bus.ex_branch_taken;
      stall  = bus.id_valid & (FWD_EN ? (h1_exl | h2_exl) : (h1_ex | h1_mem | h2_ex | h2_mem));
      bubble = stall | flush;
      f1_d   = (bubble || !FWD_EN) ? FWD_RF : (h1_ex && !h1_exl) ? FWD_EXMEM : h1_mem ? FWD_MEMWB : FWD_RF;
      f2_d   = (bubble || !FWD_EN) ? FWD_RF : (h2_ex && !h2_exl) ? FWD_EXMEM : h2_mem ? FWD_MEMWB : FWD_RF;
   end

   // A taken branch overrides a stall: the stalled ID instruction is wrong-path anyway.
   assign bus.pc_en        = rst_n & (!stall | flush);
   assign bus.if_id_en     = rst_n & (!stall | flush);
   assign bus.if_id_flush  = rst_n & flush;
   assign bus.id_ex_bubble = !rst_n | bubble;
   assign bus.fwd1_sel     = f1_q;
   assign bus.fwd2_sel     = f2_q;
   assign bus.stall_cnt    = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         f1_q  <= FWD_RF;
         f2_q  <= FWD_RF;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_t'{v: ex_q.v, dst: ex_q.dst, we: ex_q.we};
         ex_q  <= bubble ? '0 : ex_t'{v: bus.id_valid, dst: bus.id_dst, we: bus.id_dst_we, ld: bus.id_is_load};
         f1_q  <= f1_d;
         f2_q  <= f2_d;
         if (stall && !flush && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule
